// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and width helpers for the round-robin D-register bank arbiter.
package dff_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  localparam int IDX_W = idx_w(4);
  localparam int CNT_W = cnt_w(4);

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the arbiter: requests and data in, grant and register contents out.
interface dff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       REQ;
  logic [N_REQ*WIDTH-1:0] D;
  logic [N_REQ-1:0]       GNT;
  logic [WIDTH-1:0]       Q;
  logic [WIDTH-1:0]       Qn;
  logic [OWN_W-1:0]       OWNER;
  logic                   BUSY;

  modport master (output REQ, D, input GNT, Q, Qn, OWNER, BUSY);
  modport slave  (input REQ, D, output GNT, Q, Qn, OWNER, BUSY);

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the closest match to ptr wins.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// One shared WIDTH-bit D register time-shared between N_REQ requesters with round-robin grants and a hold limit.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  dff_bank_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(MAX_HOLD);

  arb_state_e       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    hold_cnt;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic [WIDTH-1:0] q;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic             own_req;
  logic             hold_last;
  logic [WIDTH-1:0] d_sel;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IW)
  ) u_pick (
    .req (bus.REQ),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Only the owner's slice is selected, so X on other slices cannot reach Q.
  assign own_req   = bus.REQ[owner];
  assign d_sel     = bus.D[owner*WIDTH +: WIDTH];
  assign hold_last = (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt      <= N_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= OWN;
          end else begin
            gnt <= '0;
          end
        end
        OWN: begin
          if (own_req) begin
            q        <= d_sel;
            hold_cnt <= hold_cnt + CW'(1);
          end
          // Hold expiry keeps its final capture; a request drop captures nothing.
          if (!own_req || hold_last) begin
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT   = gnt;
  assign bus.OWNER = owner;
  assign bus.BUSY  = busy;
  assign bus.Q     = q;
  assign bus.Qn    = ~q;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Shares one WIDTH-bit D-register (Q, Qn = ~Q) between N_REQ requesters.
Each requester raises REQ and presents data on its D slice. A round-robin arbiter grants ownership to one requester at a time. The owner's data is captured into the shared register on every rising CLK edge while it holds the grant. A hold limit bounds how long one owner keeps the register, so no requester starves.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, width of the shared register and of each requester's data slice
MAX_HOLD, 4, maximum consecutive captures per grant (1..255)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  synchronous active-low reset, sampled on rising CLK
REQ  input  N_REQ  per-requester access request, level-sensitive
D  input  N_REQ*WIDTH  requester data; slice i = D[i*WIDTH +: WIDTH]
GNT  output  N_REQ  one-hot grant, registered
Q  output  WIDTH  shared register contents
Qn  output  WIDTH  ~Q, combinational
OWNER  output  $clog2(N_REQ)  index of current/last grantee, registered
BUSY  output  1  high while in OWN state

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - Q=0, so Qn=all ones.
  - GNT=0, OWNER=0, BUSY=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0.
  - Reset overrides everything, including mid-ownership: the grant drops and no capture happens on that edge.
- States are IDLE and OWN.
- IDLE:
  - If REQ != 0, select the first i with REQ[i]=1, searching from rr_ptr upward modulo N_REQ.
  - Next edge: GNT=onehot(i), OWNER=i, BUSY=1, hold_cnt=0, state=OWN.
  - No capture occurs in IDLE; Q holds.
  - If REQ==0, stay in IDLE with GNT=0.
- OWN, with owner o:
  - Capture: if REQ[o]=1, then Q<=D slice o and hold_cnt<=hold_cnt+1 on the next edge.
  - Release: the block releases if REQ[o]=0, or if a capture is occurring with hold_cnt==MAX_HOLD-1.
  - On release, the next edge sets GNT=0, BUSY=0, rr_ptr=(o+1) mod N_REQ, state=IDLE. OWNER holds its value.
  - A release caused by hold expiry still performs that final capture. A release caused by REQ drop captures nothing.
- Latency:
  - REQ rises in IDLE at edge k, then GNT is high after edge k+1.
  - The first capture lands at edge k+2.
  - There is exactly one idle cycle between owners; no direct handover.
- Simultaneous requests resolve by the round-robin rule only. After reset, index 0 has top priority.
- REQ from non-owners is ignored during OWN.
- A requester whose hold expired may be re-granted only if no higher-priority requester (from the rotated rr_ptr) is requesting.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits and never wraps (it is cleared on grant).
  - rr_ptr wraps from N_REQ-1 to 0.
- D values of non-owners never affect Q. X on an unselected D slice must not propagate.

Decomposition:
- Package dff_arb_pkg holds:
  - state enum (IDLE, OWN)
  - localparams IDX_W=$clog2(N_REQ) and CNT_W=$clog2(MAX_HOLD+1)
- Sub-module rr_pick (combinational): REQ plus rr_ptr gives a valid flag and an index, i.e. a rotate → priority-encode → unrotate chain.
- The shared register and Q/Qn logic stay in the top module, which keeps the D flip-flop semantics: posedge CLK, Qn=~Q.

Test Plan:
1. Reset: RST_N=0 for 2 cycles with REQ=4'b1111 → Q=8'h00, Qn=8'hFF, GNT=0, BUSY=0. After release, the first grant is GNT=4'b0001.
2. Single requester: REQ[2]=1 at edge 0 with D2=8'hA5 → GNT=4'b0100 after edge 1, Q=8'hA5 after edge 2, Qn=8'h5A.
3. Hold limit: REQ[1] held high with MAX_HOLD=4 and D1 changing 01,02,03,04,05 → exactly 4 captures (Q=8'h04). GNT drops the next edge, then GNT=4'b0010 again one cycle later if REQ[1] is still the only request.
4. Round-robin fairness: REQ=4'b1111 continuously → grants 0,1,2,3,0 in order, each lasting MAX_HOLD captures, with one-cycle BUSY=0 gaps.
5. Early release: owner 3 drops REQ after 2 captures → no capture on the drop edge, so Q keeps the second value. rr_ptr=0 and the next grant goes to REQ[0] if it is asserted.
6. Reset mid-ownership: RST_N=0 during the 2nd capture cycle of owner 1 → the next edge gives Q=0, GNT=0, state IDLE, rr_ptr=0.
